// File: rtl/line_flush_pkg.sv
// Shared constants and state encoding for the line flush buffer.
// Terminators are 8-bit codes, zero-extended where compared.
package line_flush_pkg;

  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_SEND_LF
  } state_t;

endpackage

// File: rtl/line_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// A write into a full FIFO is taken when a pop happens in the same cycle.
module line_fifo #(
  parameter int BW     = 8,
  parameter int LGFLEN = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill
);

  logic [BW-1:0]   r_mem [0:(1<<LGFLEN)-1];
  logic [LGFLEN:0] r_wptr;
  logic [LGFLEN:0] r_rptr;
  logic            w_wr;
  logic            w_rd;

  assign o_fill  = r_wptr - r_rptr;
  assign o_full  = o_fill[LGFLEN];
  assign o_empty = (o_fill == '0);
  assign w_rd    = i_rd && !o_empty;
  assign w_wr    = i_wr && (!o_full || w_rd);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wptr[LGFLEN-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rptr[LGFLEN-1:0]];

endmodule

// File: rtl/line_flush_buf.sv
// Line-buffering stage between a UART receiver and transmitter.
// Releases whole lines, forced breaks, or idle-timeout partial lines.
module line_flush_buf
  import line_flush_pkg::*;
#(
  parameter int BW       = 8,
  parameter int LGFLEN   = 8,
  parameter int MAX_LINE = 80,
  parameter int TIMEOUT  = 0,
  parameter int CRLF     = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_stb,
  input  logic [BW-1:0]     i_rx_data,
  output logic              o_tx_stb,
  output logic [BW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic [LGFLEN:0]   o_lines,
  output logic              o_overflow
);

  localparam int CW  = (BW > 8) ? BW : 8;
  localparam int BGW = $clog2((1 << LGFLEN) + 1);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0]     LF_W  = CW'(CHR_LF);
  localparam logic [CW-1:0]     CR_W  = CW'(CHR_CR);
  localparam logic [BW-1:0]     LF_O  = BW'(CHR_LF);
  localparam logic [BW-1:0]     CR_O  = BW'(CHR_CR);
  localparam logic [BGW-1:0]    ML_B  = BGW'(MAX_LINE);
  localparam logic [LGFLEN:0]   ML_F  = (LGFLEN+1)'(MAX_LINE);
  localparam logic [TW-1:0]     TO_C  = TW'(TIMEOUT);
  localparam bit                CRLF_ON = (CRLF != 0);
  localparam bit                TO_ON   = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BGW-1:0]   r_budget;
  logic [BGW-1:0]   w_budget_nxt;
  logic [LGFLEN:0]  r_lines;
  logic             r_overflow;
  logic             r_cr;
  logic [TW-1:0]    r_idle;

  logic [BW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic [LGFLEN:0]  w_fill;
  logic [CW-1:0]    w_rx_ext;
  logic [CW-1:0]    w_head_ext;
  logic             w_rx_lf;
  logic             w_rx_cr;
  logic             w_rx_term;
  logic             w_head_term;
  logic             w_drop;
  logic             w_keep;
  logic             w_pop;
  logic             w_wr;
  logic             w_xfer;
  logic             w_inc;
  logic             w_dec;

  assign w_rx_ext    = CW'(i_rx_data);
  assign w_head_ext  = CW'(w_head);
  assign w_rx_lf     = (w_rx_ext == LF_W);
  assign w_rx_cr     = (w_rx_ext == CR_W);
  assign w_rx_term   = w_rx_lf || w_rx_cr;
  assign w_head_term = (w_head_ext == LF_W) || (w_head_ext == CR_W);

  // An LF right after an accepted CR is folded into that CR's line end
  assign w_drop = CRLF_ON && r_cr && w_rx_lf;
  assign w_keep = i_rx_stb && !w_drop;
  assign w_pop  = (r_state == ST_SEND) && !w_empty && !i_tx_busy;
  assign w_wr   = w_keep && (!w_full || w_pop);
  assign w_xfer = o_tx_stb && !i_tx_busy;
  assign w_inc  = w_wr && w_rx_term;
  assign w_dec  = w_pop && w_head_term;

  line_fifo #(
    .BW     (BW),
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (w_wr),
    .i_data  (i_rx_data),
    .i_rd    (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (w_fill)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lines    <= '0;
      r_overflow <= 1'b0;
      r_cr       <= 1'b0;
    end else begin
      unique case ({w_inc, w_dec})
        2'b10:   r_lines <= r_lines + 1'b1;
        2'b01:   r_lines <= r_lines - 1'b1;
        default: r_lines <= r_lines;
      endcase
      if (w_keep && w_full && !w_pop)
        r_overflow <= 1'b1;
      if (w_wr)
        r_cr <= w_rx_cr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_idle <= '0;
    else if (i_rx_stb || w_xfer)
      r_idle <= '0;
    else if (!w_empty && (r_idle != TO_C))
      r_idle <= r_idle + TW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_budget <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_budget <= w_budget_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_budget_nxt = r_budget;
    o_tx_stb     = 1'b0;
    o_tx_data    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if ((r_lines != '0) || (w_fill >= ML_F)) begin
          w_state_nxt  = ST_SEND;
          w_budget_nxt = ML_B;
        end else if (TO_ON && (r_idle == TO_C) && !w_empty) begin
          w_state_nxt  = ST_SEND;
          w_budget_nxt = BGW'(w_fill);
        end
      end
      ST_SEND: begin
        o_tx_stb  = !w_empty;
        o_tx_data = (CRLF_ON && w_head_term) ? CR_O : w_head;
        if (w_pop) begin
          w_budget_nxt = r_budget - 1'b1;
          if (w_head_term)
            w_state_nxt = CRLF_ON ? ST_SEND_LF : ST_IDLE;
          else if (r_budget == BGW'(1))
            w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND_LF: begin
        o_tx_stb  = 1'b1;
        o_tx_data = LF_O;
        if (!i_tx_busy)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_fill     = w_fill;
  assign o_lines    = r_lines;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_line_flush_buf.sv
// Bench for line_flush_buf: two instances, one plain with forced
// break and timeout, one small CRLF instance for overflow and reset.
module tb_line_flush_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_stb  = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_busy = 1'b0;
  logic       a_tx_stb;
  logic [7:0] a_tx_data;
  logic [3:0] a_fill;
  logic [3:0] a_lines;
  logic       a_ovf;

  logic       b_stb  = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_busy = 1'b0;
  logic       b_tx_stb;
  logic [7:0] b_tx_data;
  logic [2:0] b_fill;
  logic [2:0] b_lines;
  logic       b_ovf;

  int checks = 0;
  int errors = 0;
  int n_xa   = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  line_flush_buf #(
    .BW(8), .LGFLEN(3), .MAX_LINE(4), .TIMEOUT(10), .CRLF(0)
  ) u_a (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_stb   (a_stb),
    .i_rx_data  (a_data),
    .o_tx_stb   (a_tx_stb),
    .o_tx_data  (a_tx_data),
    .i_tx_busy  (a_busy),
    .o_fill     (a_fill),
    .o_lines    (a_lines),
    .o_overflow (a_ovf)
  );

  line_flush_buf #(
    .BW(8), .LGFLEN(2), .MAX_LINE(4), .TIMEOUT(0), .CRLF(1)
  ) u_b (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_stb   (b_stb),
    .i_rx_data  (b_data),
    .o_tx_stb   (b_tx_stb),
    .o_tx_data  (b_tx_data),
    .i_tx_busy  (b_busy),
    .o_fill     (b_fill),
    .o_lines    (b_lines),
    .o_overflow (b_ovf)
  );

  // A transfer seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (a_tx_stb && !a_busy) begin
      logic [7:0] e;
      n_xa++;
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_xfer unexpected got=%02h want none", a_tx_data);
      end else begin
        e = exp_a.pop_front();
        if (a_tx_data !== e) begin
          errors++;
          $display("FAIL a_xfer got=%02h want=%02h", a_tx_data, e);
        end
      end
    end
    if (b_tx_stb && !b_busy) begin
      logic [7:0] e;
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_xfer unexpected got=%02h want none", b_tx_data);
      end else begin
        e = exp_b.pop_front();
        if (b_tx_data !== e) begin
          errors++;
          $display("FAIL b_xfer got=%02h want=%02h", b_tx_data, e);
        end
      end
    end
  end

  task automatic rx_a(input logic [7:0] c);
    @(posedge clk); #1;
    a_stb  = 1'b1;
    a_data = c;
  endtask

  task automatic rx_a_end();
    @(posedge clk); #1;
    a_stb = 1'b0;
  endtask

  task automatic rx_b(input logic [7:0] c);
    @(posedge clk); #1;
    b_stb  = 1'b1;
    b_data = c;
  endtask

  task automatic rx_b_end();
    @(posedge clk); #1;
    b_stb = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_fill !== 4'd0) begin
      errors++; $display("FAIL rst_a_fill got=%0d want=0", a_fill);
    end
    checks++;
    if (a_lines !== 4'd0) begin
      errors++; $display("FAIL rst_a_lines got=%0d want=0", a_lines);
    end
    checks++;
    if (a_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_a_ovf got=%b want=0", a_ovf);
    end
    checks++;
    if (a_tx_stb !== 1'b0) begin
      errors++; $display("FAIL rst_a_stb got=%b want=0", a_tx_stb);
    end
    checks++;
    if (a_tx_data !== 8'h00) begin
      errors++; $display("FAIL rst_a_data got=%02h want=00", a_tx_data);
    end
    checks++;
    if (b_fill !== 3'd0) begin
      errors++; $display("FAIL rst_b_fill got=%0d want=0", b_fill);
    end
    checks++;
    if (b_lines !== 3'd0) begin
      errors++; $display("FAIL rst_b_lines got=%0d want=0", b_lines);
    end
    checks++;
    if (b_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_b_ovf got=%b want=0", b_ovf);
    end
    checks++;
    if (b_tx_stb !== 1'b0) begin
      errors++; $display("FAIL rst_b_stb got=%b want=0", b_tx_stb);
    end
  endtask

  task automatic test_single_line();
    logic [7:0] msg[3];
    logic       want_stb[5];
    msg = '{8'h41, 8'h42, 8'h0A};
    want_stb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    foreach (msg[i]) exp_a.push_back(msg[i]);
    foreach (msg[i]) rx_a(msg[i]);
    rx_a_end();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_tx_stb !== want_stb[k]) begin
        errors++;
        $display("FAIL single_stb cyc=%0d got=%b want=%b",
                 k + 1, a_tx_stb, want_stb[k]);
      end
      if (k == 0) begin
        checks++;
        if (a_lines !== 4'd1) begin
          errors++; $display("FAIL single_lines1 got=%0d want=1", a_lines);
        end
      end
    end
    checks++;
    if (a_lines !== 4'd0) begin
      errors++; $display("FAIL single_lines0 got=%0d want=0", a_lines);
    end
    checks++;
    if (exp_a.size() != 0) begin
      errors++; $display("FAIL single_left got=%0d want=0", exp_a.size());
    end
  endtask

  task automatic test_multi_line();
    logic [7:0] msg[5];
    int n;
    msg = '{8'h41, 8'h0A, 8'h42, 8'h43, 8'h0A};
    @(posedge clk); #1 a_busy = 1'b1;
    foreach (msg[i]) exp_a.push_back(msg[i]);
    foreach (msg[i]) rx_a(msg[i]);
    rx_a_end();
    @(negedge clk);
    checks++;
    if (a_lines !== 4'd2) begin
      errors++; $display("FAIL multi_lines got=%0d want=2", a_lines);
    end
    checks++;
    if (a_fill !== 4'd5) begin
      errors++; $display("FAIL multi_fill got=%0d want=5", a_fill);
    end
    @(posedge clk); #1 a_busy = 1'b0;
    n = 0;
    while (exp_a.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (exp_a.size() != 0) begin
      errors++; $display("FAIL multi_drain left=%0d want=0", exp_a.size());
    end
    @(negedge clk);
    checks++;
    if (a_lines !== 4'd0) begin
      errors++; $display("FAIL multi_lines_end got=%0d want=0", a_lines);
    end
  endtask

  task automatic test_forced_break();
    logic [7:0] msg[6];
    int n;
    int base;
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    foreach (msg[i]) exp_a.push_back(msg[i]);
    base = n_xa;
    foreach (msg[i]) rx_a(msg[i]);
    rx_a_end();
    n = 0;
    while ((n_xa - base) < 4 && n < 40) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (a_fill !== 4'd2) begin
      errors++; $display("FAIL break_fill got=%0d want=2", a_fill);
    end
    checks++;
    if (a_tx_stb !== 1'b0) begin
      errors++; $display("FAIL break_idle got=%b want=0", a_tx_stb);
    end
    checks++;
    if (exp_a.size() != 2) begin
      errors++; $display("FAIL break_sent left=%0d want=2", exp_a.size());
    end
    n = 0;
    while (exp_a.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (exp_a.size() != 0) begin
      errors++; $display("FAIL break_tail left=%0d want=0", exp_a.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_a.push_back(8'h58);
    exp_a.push_back(8'h59);
    rx_a(8'h58);
    rx_a(8'h59);
    rx_a_end();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!a_tx_stb && n < 40);
    checks++;
    if (n != 12) begin
      errors++; $display("FAIL timeout_latency got=%0d want=12", n);
    end
    n = 0;
    while (exp_a.size() != 0 && n < 40) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (exp_a.size() != 0) begin
      errors++; $display("FAIL timeout_drain left=%0d want=0", exp_a.size());
    end
    checks++;
    if (a_fill !== 4'd0) begin
      errors++; $display("FAIL timeout_fill got=%0d want=0", a_fill);
    end
  endtask

  task automatic test_crlf();
    logic [7:0] msg[5];
    logic [7:0] out[6];
    int n;
    msg = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A};
    out = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0D, 8'h0A};
    foreach (out[i]) exp_b.push_back(out[i]);
    foreach (msg[i]) rx_b(msg[i]);
    rx_b_end();
    n = 0;
    while (exp_b.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (exp_b.size() != 0) begin
      errors++; $display("FAIL crlf_drain left=%0d want=0", exp_b.size());
    end
    checks++;
    if (b_ovf !== 1'b0) begin
      errors++; $display("FAIL crlf_ovf got=%b want=0", b_ovf);
    end
    checks++;
    if (b_lines !== 3'd0 || b_fill !== 3'd0) begin
      errors++;
      $display("FAIL crlf_empty lines=%0d fill=%0d want 0 0", b_lines, b_fill);
    end
  endtask

  task automatic test_overflow_reset();
    @(posedge clk); #1 b_busy = 1'b1;
    for (int i = 0; i < 4; i++) rx_b(8'h61 + 8'(i));
    rx_b_end();
    @(negedge clk);
    checks++;
    if (b_fill !== 3'd4 || b_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre fill=%0d ovf=%b want 4 0", b_fill, b_ovf);
    end
    rx_b(8'h65);
    rx_b_end();
    @(negedge clk);
    checks++;
    if (b_fill !== 3'd4) begin
      errors++; $display("FAIL ovf_fill got=%0d want=4", b_fill);
    end
    checks++;
    if (b_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got=%b want=1", b_ovf);
    end
    checks++;
    if (b_tx_stb !== 1'b1) begin
      errors++; $display("FAIL ovf_stb got=%b want=1", b_tx_stb);
    end
    rx_b(8'h66);
    rx_b_end();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b_fill !== 3'd0 || b_lines !== 3'd0) begin
      errors++;
      $display("FAIL rst2_count fill=%0d lines=%0d want 0 0", b_fill, b_lines);
    end
    checks++;
    if (b_ovf !== 1'b0) begin
      errors++; $display("FAIL rst2_ovf got=%b want=0", b_ovf);
    end
    checks++;
    if (b_tx_stb !== 1'b0) begin
      errors++; $display("FAIL rst2_stb got=%b want=0", b_tx_stb);
    end
    @(posedge clk); #1 b_busy = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (b_tx_stb !== 1'b0) begin
      errors++; $display("FAIL rst2_quiet got=%b want=0", b_tx_stb);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_line();
    test_multi_line();
    test_forced_break();
    test_timeout();
    test_crlf();
    test_overflow_reset();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
